// File: rtl/tx_dll_replay_buffer.sv
// Transmit data link layer: sequence numbering, CRC-8 LCRC and a replay buffer
// that holds every frame until acked, rewinding on nack or replay timeout.
module tx_dll_replay_buffer #(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned REPLAY_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] tlp_data_in,
  input  logic        tlp_data_in_valid,
  output logic        tlp_data_in_ready,
  output logic [31:0] tlp_data_out,
  output logic        tlp_data_out_valid,
  input  logic        tlp_data_out_ready,
  input  logic        ack,
  input  logic        nack,
  output logic        replay,
  output logic        retrain
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(REPLAY_TIMEOUT);

  logic [3:0]    wr_seq;
  logic [3:0]    rd_seq;
  logic [3:0]    ack_seq;
  logic [TW-1:0] timer;
  logic [1:0]    replay_cnt;
  logic [31:0]   mem [DEPTH];

  logic [3:0]  outstanding;
  logic        full;
  logic        unacked;
  logic        timeout;
  logic        rewind;
  logic        accept;
  logic        send;
  logic        ack_take;
  logic [31:0] frame_in;

  // CRC-8, poly 0x07, init 0, MSB first, no reflection or final XOR
  function automatic logic [7:0] lcrc(input logic [23:0] d);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 23; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  assign outstanding = wr_seq - ack_seq;
  assign full        = (outstanding == 4'(DEPTH));
  assign unacked     = (ack_seq != rd_seq);
  assign timeout     = unacked && (timer == TW'(REPLAY_TIMEOUT - 1));
  assign rewind      = nack | timeout;
  assign accept      = tlp_data_in_valid & ~full;
  // A rewind pre-empts both the output handshake and any ack in the same cycle
  assign send        = tlp_data_out_valid & tlp_data_out_ready & ~rewind;
  assign ack_take    = ack & unacked & ~rewind;
  assign frame_in    = {wr_seq, tlp_data_in, lcrc({wr_seq, tlp_data_in})};

  assign tlp_data_in_ready  = ~full;
  assign tlp_data_out_valid = (rd_seq != wr_seq);
  assign tlp_data_out       = tlp_data_out_valid ? mem[rd_seq[IW-1:0]] : 32'h0;

  // Frame storage, indexed by sequence number modulo DEPTH
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_seq[IW-1:0]] <= frame_in;
    end
  end

  // Pointers, replay timer and consecutive-replay counter
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_seq     <= 4'd0;
      rd_seq     <= 4'd0;
      ack_seq    <= 4'd0;
      timer      <= '0;
      replay_cnt <= 2'd0;
      replay     <= 1'b0;
      retrain    <= 1'b0;
    end else begin
      replay  <= rewind;
      retrain <= 1'b0;
      if (accept) begin
        wr_seq <= wr_seq + 4'd1;
      end
      if (rewind) begin
        rd_seq <= ack_seq;
        timer  <= '0;
        if (replay_cnt == 2'd3) begin
          retrain    <= 1'b1;
          replay_cnt <= 2'd0;
        end else begin
          replay_cnt <= replay_cnt + 2'd1;
        end
      end else begin
        if (send) begin
          rd_seq <= rd_seq + 4'd1;
        end
        if (ack_take) begin
          ack_seq    <= ack_seq + 4'd1;
          replay_cnt <= 2'd0;
          timer      <= '0;
        end else if (unacked) begin
          timer <= timer + TW'(1);
        end else begin
          timer <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_tx_dll_replay_buffer.sv
// Randomized scoreboard bench for tx_dll_replay_buffer with an abstract
// integer-counter reference model.
module tb_tx_dll_replay_buffer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned T     = 16;

  logic        clk;
  logic        reset;
  logic [19:0] tlp_data_in;
  logic        tlp_data_in_valid;
  logic        tlp_data_in_ready;
  logic [31:0] tlp_data_out;
  logic        tlp_data_out_valid;
  logic        tlp_data_out_ready;
  logic        ack;
  logic        nack;
  logic        replay;
  logic        retrain;

  tx_dll_replay_buffer #(.DEPTH(DEPTH), .REPLAY_TIMEOUT(T)) dut (
    .clk                (clk),
    .reset              (reset),
    .tlp_data_in        (tlp_data_in),
    .tlp_data_in_valid  (tlp_data_in_valid),
    .tlp_data_in_ready  (tlp_data_in_ready),
    .tlp_data_out       (tlp_data_out),
    .tlp_data_out_valid (tlp_data_out_valid),
    .tlp_data_out_ready (tlp_data_out_ready),
    .ack                (ack),
    .nack               (nack),
    .replay             (replay),
    .retrain            (retrain)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  // Reference model: unbounded frame counters, payload store keyed by seq
  int          m_wr, m_rd, m_ak, m_timer, m_rcnt;
  logic [19:0] m_pay [16];
  bit          m_replay, m_retrain;
  int          dut_retrains;

  function automatic logic [7:0] ref_crc(input logic [23:0] d);
    logic [31:0] r;
    r = {d, 8'h00};
    for (int i = 31; i >= 8; i--)
      if (r[i]) r = r ^ (32'h107 << (i - 8));
    return r[7:0];
  endfunction

  function automatic logic [31:0] exp_frame(input int s);
    logic [3:0]  sq;
    logic [19:0] pd;
    sq = 4'(s % 16);
    pd = m_pay[s % 16];
    return {sq, pd, ref_crc({sq, pd})};
  endfunction

  function automatic void model_reset();
    m_wr = 0; m_rd = 0; m_ak = 0; m_timer = 0; m_rcnt = 0;
    m_replay = 0; m_retrain = 0;
  endfunction

  function automatic void model_step(input bit iv, input logic [19:0] d,
                                     input bit orr, input bit a, input bit n);
    bit unacked, was_valid, rewind;
    unacked   = (m_ak != m_rd);
    was_valid = (m_rd != m_wr);
    rewind    = n || (unacked && m_timer == int'(T) - 1);
    m_replay  = rewind;
    m_retrain = 0;
    if (iv && (m_wr - m_ak) < int'(DEPTH)) begin
      m_pay[m_wr % 16] = d;
      m_wr++;
    end
    if (rewind) begin
      m_rd    = m_ak;
      m_timer = 0;
      m_rcnt++;
      if (m_rcnt == 4) begin
        m_retrain = 1;
        m_rcnt    = 0;
      end
    end else begin
      if (was_valid && orr) m_rd++;
      if (a && unacked) begin
        m_ak++;
        m_rcnt  = 0;
        m_timer = 0;
      end else begin
        m_timer = unacked ? m_timer + 1 : 0;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("in_ready", 32'(tlp_data_in_ready), 32'((m_wr - m_ak) < int'(DEPTH)));
    chk("out_valid", 32'(tlp_data_out_valid), 32'(m_rd != m_wr));
    chk("replay", 32'(replay), 32'(m_replay));
    chk("retrain", 32'(retrain), 32'(m_retrain));
    if (m_rd == m_wr) chk("out_data_idle", tlp_data_out, 32'h0);
    if (retrain === 1'b1) dut_retrains++;
  endtask

  // One clock cycle: drive inputs, predict the presented frame, advance model
  task automatic cycle(input bit iv, input logic [19:0] d, input bit orr,
                       input bit a, input bit n);
    tlp_data_in_valid  = iv;
    tlp_data_in        = d;
    tlp_data_out_ready = orr;
    ack                = a;
    nack               = n;
    if (m_rd != m_wr && orr) exp_q.push_back(exp_frame(m_rd));
    @(posedge clk);
    model_step(iv, d, orr, a, n);
    #2;
    check_outputs();
  endtask

  task automatic do_reset();
    tlp_data_in_valid  = 0;
    tlp_data_in        = '0;
    tlp_data_out_ready = 0;
    ack                = 0;
    nack               = 0;
    reset              = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    model_reset();
    #1;
    check_outputs();
    chk("reset_data", tlp_data_out, 32'h0);
  endtask

  // Scoreboard monitor: every presented handshake pops one expected frame
  always @(negedge clk) begin
    if (!reset && tlp_data_out_valid && tlp_data_out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL frame_unexpected: got %h expected none at %0t", tlp_data_out, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        if (tlp_data_out !== mon_exp) begin
          errors++;
          $display("FAIL frame: got %h expected %h at %0t", tlp_data_out, mon_exp, $time);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    dut_retrains = 0;
    do_reset();

    // First frame after reset
    cycle(1, 20'h00001, 0, 0, 0);
    chk("first_frame", tlp_data_out, 32'h00000107);
    cycle(0, '0, 1, 0, 0);
    cycle(0, '0, 0, 1, 0);

    // Fill to DEPTH without acks, then one ack frees a slot
    repeat (DEPTH) cycle(1, 20'($urandom), 1, 0, 0);
    chk("full_not_ready", 32'(tlp_data_in_ready), 32'h0);
    cycle(0, '0, 1, 1, 0);
    chk("ready_after_ack", 32'(tlp_data_in_ready), 32'h1);

    // Nack rewinds to oldest unacked frame
    cycle(0, '0, 1, 0, 1);
    chk("nack_replay", 32'(replay), 32'h1);
    repeat (12) cycle(1, 20'($urandom), 1, 0, 0);
    repeat (20) cycle(0, '0, 1, 1, 0);

    // Timeouts with ack withheld: four consecutive replays trigger retrain
    base = dut_retrains;
    cycle(1, 20'($urandom), 1, 0, 0);
    repeat (4 * T + 10) cycle(0, '0, 1, 0, 0);
    chk("retrain_once", 32'(dut_retrains - base), 32'h1);
    repeat (4) cycle(0, '0, 1, 1, 0);

    // Same-cycle ack and nack, then a spurious ack
    cycle(1, 20'($urandom), 1, 0, 0);
    cycle(1, 20'($urandom), 1, 0, 0);
    cycle(0, '0, 1, 0, 0);
    cycle(0, '0, 0, 1, 1);
    chk("ack_nack_replay", 32'(replay), 32'h1);
    repeat (8) cycle(0, '0, 1, 1, 0);
    cycle(0, '0, 0, 1, 0);

    // Forty frames back to back with immediate acks, wrapping seq twice
    repeat (40) cycle(1, 20'($urandom), 1, 1, 0);
    repeat (4) cycle(0, '0, 1, 1, 0);

    // Reset mid-stream, then seq restarts at 0
    repeat (5) cycle(1, 20'($urandom), 1, 0, 0);
    do_reset();
    cycle(1, 20'hABCDE, 0, 0, 0);
    chk("post_reset_seq0", 32'(tlp_data_out[31:28]), 32'h0);

    // Randomized traffic
    repeat (3000) begin
      cycle($urandom_range(0, 9) < 7, 20'($urandom), $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) < 3, $urandom_range(0, 99) < 3);
    end
    repeat (60) cycle(0, '0, 1, 1, 0);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
